// File: rtl/seq_tx_fsm.sv
// Serial frame transmitter: preamble, MSB-first data byte, optional even parity, stop.
// All outputs are registered and show the bit for the state being entered.
module seq_tx_fsm #(
  parameter int         PRE_LEN   = 3,
  parameter logic [7:0] PRE_PAT   = 8'b0000_0110,
  parameter bit         PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       x_out,
  output logic       busy,
  output logic       done
);

  localparam int CNT_MAX = (PRE_LEN > 8) ? PRE_LEN : 8;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(7);

  // preamble left-aligned so its first bit sits in bit 7
  localparam logic [7:0] PRE_ALIGN = PRE_PAT << (8 - PRE_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_PAR  = 3'd3,
    S_STOP = 3'd4
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [7:0]    sh_q, sh_n;
  logic [7:0]    pre_q, pre_n;
  logic          par_q, par_n;
  logic          x_q, x_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pre_q   <= '0;
      par_q   <= 1'b0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
      pre_q   <= pre_n;
      par_q   <= par_n;
      x_q     <= x_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sh_n    = sh_q;
    pre_n   = pre_q;
    par_n   = par_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_PRE;
          cnt_n   = '0;
          sh_n    = data_in;
          par_n   = ^data_in;
          pre_n   = PRE_ALIGN;
        end
      end
      S_PRE: begin
        pre_n = pre_q << 1;
        if (cnt_q == PRE_LAST) begin
          state_n = S_DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        sh_n = sh_q << 1;
        if (cnt_q == DATA_LAST) begin
          state_n = PARITY_EN ? S_PAR : S_STOP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_PAR: begin
        state_n = S_STOP;
        cnt_n   = '0;
      end
      S_STOP: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        sh_n    = '0;
        pre_n   = '0;
        par_n   = 1'b0;
      end
    endcase
  end

  // outputs follow the state being entered, giving one-cycle latency
  always_comb begin
    x_n    = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state_n)
      S_PRE: begin
        x_n    = pre_n[7];
        busy_n = 1'b1;
      end
      S_DATA: begin
        x_n    = sh_n[7];
        busy_n = 1'b1;
      end
      S_PAR: begin
        x_n    = par_n;
        busy_n = 1'b1;
      end
      S_STOP: begin
        busy_n = 1'b1;
        done_n = 1'b1;
      end
      default: begin
        x_n    = 1'b0;
        busy_n = 1'b0;
        done_n = 1'b0;
      end
    endcase
  end

  assign x_out = x_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_tx_fsm.sv
// Scoreboard bench for seq_tx_fsm: default instance plus a no-parity instance.
// Stimulus pushes expected {x_out,done} per busy cycle; monitors pop and compare.
module tb_seq_tx_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start2;
  logic [7:0] data_in;
  logic       x1, busy1, done1;
  logic       x2, busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] q1[$];
  logic [1:0] q2[$];

  always #5 clk = ~clk;

  seq_tx_fsm u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .start  (start1),
    .data_in(data_in),
    .x_out  (x1),
    .busy   (busy1),
    .done   (done1)
  );

  seq_tx_fsm #(.PARITY_EN(1'b0)) u_dut2 (
    .clk    (clk),
    .reset  (reset),
    .start  (start2),
    .data_in(data_in),
    .x_out  (x2),
    .busy   (busy2),
    .done   (done2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitors: busy acts as output-valid
  always @(negedge clk) begin
    if (busy1 === 1'b1) begin
      if (q1.size() == 0) chk("dut1_unexpected_busy", 32'd1, 32'd0);
      else chk("dut1_x_done", {30'd0, x1, done1}, {30'd0, q1.pop_front()});
    end else if (done1 === 1'b1) begin
      chk("dut1_done_while_idle", 32'd1, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (busy2 === 1'b1) begin
      if (q2.size() == 0) chk("dut2_unexpected_busy", 32'd1, 32'd0);
      else chk("dut2_x_done", {30'd0, x2, done2}, {30'd0, q2.pop_front()});
    end else if (done2 === 1'b1) begin
      chk("dut2_done_while_idle", 32'd1, 32'd0);
    end
  end

  task automatic push_frame(input logic [15:0] bits, input int len,
                            input bit sel2);
    for (int i = len - 1; i >= 0; i--) begin
      if (sel2) q2.push_back({bits[i], i == 0});
      else      q1.push_back({bits[i], i == 0});
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] bits,
                      input int len, input bit sel2);
    data_in = d;
    push_frame(bits, len, sel2);
    if (sel2) start2 = 1'b1;
    else      start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    start1  = 1'b0;
    start2  = 1'b0;
    data_in = 8'h00;
    cycles(2);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state_dut1", {29'd0, x1, busy1, done1}, 32'd0);
    chk("reset_state_dut2", {29'd0, x2, busy2, done2}, 32'd0);
    @(posedge clk); #1;

    // A5: 110 10100101 p=0 stop 0
    send(8'hA5, 16'b1101010010100, 13, 1'b0);
    cycles(15);
    chk("a5_frame_drained", q1.size(), 32'd0);

    // 07: 110 00000111 p=1 stop 0
    send(8'h07, 16'b1100000011110, 13, 1'b0);
    cycles(15);
    chk("h07_frame_drained", q1.size(), 32'd0);

    // no parity, FF: 110 11111111 stop 0 (12 cycles)
    send(8'hFF, 16'b110111111110, 12, 1'b1);
    cycles(14);
    chk("ff_noparity_drained", q2.size(), 32'd0);

    // start held 40 cycles: frames at 1, 15, 29
    data_in = 8'hA5;
    for (int f = 0; f < 3; f++) push_frame(16'b1101010010100, 13, 1'b0);
    start1 = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(posedge clk); #1;
      if (c == 40) start1 = 1'b0;
      @(negedge clk);
      chk($sformatf("held_busy_c%0d", c), {31'd0, busy1},
          {31'd0, (c % 14) != 0});
    end
    @(posedge clk); #1;
    cycles(3);
    chk("held_frames_drained", q1.size(), 32'd0);

    // reset in 5th DATA cycle (frame cycle 8), start asserted with it
    send(8'h5A, 16'b1100101101000, 13, 1'b0);
    cycles(7);
    reset  = 1'b1;
    start1 = 1'b1;
    cycles(1);
    reset  = 1'b0;
    start1 = 1'b0;
    chk("reset_popped_eight", q1.size(), 32'd5);
    q1.delete();
    @(negedge clk);
    chk("reset_abort_outputs", {29'd0, x1, busy1, done1}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_start_ignored", {31'd0, busy1}, 32'd0);
    @(posedge clk); #1;

    // C3 after reset: 110 11000011 p=0 stop 0
    send(8'hC3, 16'b1101100001100, 13, 1'b0);
    cycles(15);
    chk("post_reset_drained", q1.size(), 32'd0);

    // 3C with data_in churn and mid-frame start pulses: 110 00111100 p=0 0
    send(8'h3C, 16'b1100011110000, 13, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      data_in = 8'($urandom);
      start1  = (c == 2 || c == 5 || c == 13);
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    @(negedge clk);
    chk("toggle_no_extra_frame", {31'd0, busy1}, 32'd0);
    chk("toggle_drained", q1.size(), 32'd0);

    cycles(5);
    chk("final_q1_empty", q1.size(), 32'd0);
    chk("final_q2_empty", q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_tx_fsm.md
SEQ_TX_FSM -- requirements
Module: seq_tx_fsm

Interface
REQ-001 Parameter PRE_LEN, default 3: number of preamble bits sent ahead of each frame (legal range 1..8).
REQ-002 Parameter PRE_PAT, default 8'b0000_0110: preamble pattern; low PRE_LEN bits used, sent bit PRE_LEN-1 first.
REQ-003 Parameter PARITY_EN, default 1: 1 = even-parity bit appended after data; 0 = parity slot omitted.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  frame request; sampled only in IDLE.
REQ-007 data_in  input  8  payload, captured on the accepting edge.
REQ-008 x_out  output  1  registered serial bit stream feeding the downstream x_in detector.
REQ-009 busy  output  1  registered; high while a frame is in progress.
REQ-010 done  output  1  registered; one-cycle pulse marking the final (stop) cycle of a frame.

Function
REQ-011 The block SHALL implement states IDLE, PRE, DATA, PAR, STOP as an explicit encoded state register.
REQ-012 IDLE: x_out=0, busy=0, done=0; start=1 at an edge SHALL latch data_in into an 8-bit shift register, compute parity, clear bit counter, move to PRE.
REQ-013 PRE: x_out SHALL present PRE_PAT[PRE_LEN-1] down to PRE_PAT[0], one bit per cycle, for exactly PRE_LEN cycles, then go to DATA.
REQ-014 DATA: x_out SHALL present the latched byte MSB first, one bit per cycle, 8 cycles, then go to PAR (PARITY_EN=1) or STOP (PARITY_EN=0).
REQ-015 PAR: x_out SHALL equal XOR of the 8 latched data bits for one cycle, then go to STOP.
REQ-016 STOP: x_out=0, done=1, busy=1 for one cycle, then return to IDLE.
REQ-017 busy SHALL be 1 in every PRE, DATA, PAR, STOP cycle and 0 in IDLE.
REQ-018 First frame bit SHALL appear on x_out in the cycle after the accepting edge (latency 1); busy rises in that same cycle.
REQ-019 Frame length SHALL be PRE_LEN+8+PARITY_EN+1 busy cycles (13 with defaults).
REQ-020 start while busy (including the STOP cycle) SHALL be ignored, with no queuing.
REQ-021 start held high continuously SHALL yield back-to-back frames separated by exactly one IDLE cycle.
REQ-022 Changes on data_in after acceptance SHALL NOT affect the frame in progress.
REQ-023 Bit counter SHALL be wide enough for max(PRE_LEN, 8) and SHALL reset to 0 on every state transition.
REQ-024 Unreachable state encodings SHALL transition to IDLE on the next edge.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, x_out=0, busy=0, done=0, and clear the shift register and counter, regardless of state.
REQ-026 Reset mid-frame SHALL abort the frame with no done pulse; start asserted with reset SHALL be ignored.
REQ-027 After reset deasserts, the first start SHALL be accepted at the next edge in IDLE.

Verification
REQ-028 Defaults, data_in=8'hA5, 1-cycle start -> x_out over 13 cycles = 1,1,0, 1,0,1,0,0,1,0,1, 0, 0; busy=1 for those 13 cycles; done=1 only in the 13th.
REQ-029 Defaults, data_in=8'h07 -> data bits 0,0,0,0,0,1,1,1; parity bit=1; stop bit=0.
REQ-030 PARITY_EN=0, data_in=8'hFF -> 12 busy cycles: 1,1,0, eight 1s, 0; done in the 12th cycle.
REQ-031 start held high for 40 cycles, defaults -> frames begin at cycles 1, 15, 29; exactly one IDLE cycle (busy=0) between frames.
REQ-032 reset asserted in the 5th DATA cycle -> next cycle x_out=0, busy=0, done=0, no done pulse; a new start afterward produces a full correct frame.
REQ-033 data_in toggled every cycle during a frame, plus start pulses mid-frame -> output frame matches the byte captured at acceptance; no extra frames.
